// File: rtl/logic_eqn_pkg.sv
// rtl/logic_eqn_pkg.sv - shared types and golden truth tables for the logic-equation BIST
//
// Purpose: FSM state encoding, vector count and the golden truth tables of the
// two-output equation unit F1 = XZ + YZ', F2 = XY' + YZ'. Tables are indexed by
// vec = {X,Y,Z}.
// Ports: none (package).

package logic_eqn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VEC = 8;

    // Bit v is the expected output for vector v.
    localparam logic [NUM_VEC-1:0] F1_TT = 8'b1110_0100;
    localparam logic [NUM_VEC-1:0] F2_TT = 8'b0111_0100;

    function automatic logic [1:0] golden_lookup(input logic [2:0] vec);
        return {F1_TT[vec], F2_TT[vec]};
    endfunction

endpackage

// File: rtl/logic_eqn_golden.sv
// rtl/logic_eqn_golden.sv - combinational golden model of the two-output equation unit
//
// Purpose: maps the vector under test to the expected F1/F2 values.
// Ports:
//   vec_i     in   3  vector under test, {X,Y,Z}
//   f1_exp_o  out  1  expected F1
//   f2_exp_o  out  1  expected F2

module logic_eqn_golden
    import logic_eqn_pkg::*;
(
    input  logic [2:0] vec_i,
    output logic       f1_exp_o,
    output logic       f2_exp_o
);

    assign {f1_exp_o, f2_exp_o} = golden_lookup(vec_i);

endmodule

// File: rtl/logic_eqn_bist_ctrl.sv
// rtl/logic_eqn_bist_ctrl.sv - BIST sequencer sweeping and checking the logic-equation unit
//
// Purpose: on start, drives all 8 {X,Y,Z} vectors into the equation unit, holds
// each for SETTLE_CYCLES cycles, samples F1/F2 and compares them with the golden
// tables. Reports pass, mismatch count and a bitmap of failing vectors.
// Optional build macro STOP_ON_FAIL_EN: the first mismatch ends the sweep and the
// failing vector stays on x/y/z for debug.
// Ports:
//   clk_i        in   1  clock, rising edge
//   rst_i        in   1  synchronous active-high reset
//   start_i      in   1  start request, honoured in IDLE or DONE
//   x_o,y_o,z_o  out  1  registered test vector, {x,y,z} = vec
//   f1_i,f2_i    in   1  equation-unit outputs
//   busy_o       out  1  sweep in progress
//   done_o       out  1  sweep complete, held until restart or reset
//   pass_o       out  1  done with zero mismatches
//   fail_cnt_o   out  4  number of mismatching vectors
//   fail_vec_o   out  8  bit v set when vector v mismatched

module logic_eqn_bist_ctrl
    import logic_eqn_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       x_o,
    output logic       y_o,
    output logic       z_o,
    input  logic       f1_i,
    input  logic       f2_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [3:0] fail_cnt_o,
    output logic [7:0] fail_vec_o
);

    localparam logic [3:0] SCNT_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [2:0] VEC_LAST  = 3'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] scnt_q, scnt_d;
    logic [3:0] fail_cnt_q, fail_cnt_d;
    logic [7:0] fail_vec_q, fail_vec_d;

    logic f1_exp, f2_exp;
    logic mismatch;
    logic end_sweep;

    logic_eqn_golden u_golden (
        .vec_i    (vec_q),
        .f1_exp_o (f1_exp),
        .f2_exp_o (f2_exp)
    );

    assign mismatch = (f1_i != f1_exp) || (f2_i != f2_exp);

`ifdef STOP_ON_FAIL_EN
    assign end_sweep = mismatch || (vec_q == VEC_LAST);
`else
    assign end_sweep = (vec_q == VEC_LAST);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            vec_q      <= 3'd0;
            scnt_q     <= 4'd0;
            fail_cnt_q <= 4'd0;
            fail_vec_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            scnt_q     <= scnt_d;
            fail_cnt_q <= fail_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        scnt_d     = scnt_q;
        fail_cnt_d = fail_cnt_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            // IDLE and DONE share the restart path; results clear on the same
            // edge that enters DRIVE.
            IDLE, DONE: begin
                if (start_i) begin
                    state_d    = DRIVE;
                    vec_d      = 3'd0;
                    scnt_d     = 4'd0;
                    fail_cnt_d = 4'd0;
                    fail_vec_d = 8'd0;
                end
            end
            DRIVE: begin
                scnt_d = scnt_q + 4'd1;
                if (scnt_q == SCNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_vec_d[vec_q] = 1'b1;
                    fail_cnt_d        = fail_cnt_q + 4'd1;
                end
                // On the final vector vec is left alone so x/y/z keep showing it.
                if (end_sweep) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + 3'd1;
                    scnt_d  = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // vec is only non-zero after a start, so IDLE always presents 000.
    assign {x_o, y_o, z_o} = vec_q;
    assign busy_o     = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done_o     = (state_q == DONE);
    assign pass_o     = done_o && (fail_cnt_q == 4'd0);
    assign fail_cnt_o = fail_cnt_q;
    assign fail_vec_o = fail_vec_q;

endmodule

// File: tb/tb_logic_eqn_bist_ctrl.sv
// tb/tb_logic_eqn_bist_ctrl.sv - self-checking bench for logic_eqn_bist_ctrl

module tb_logic_eqn_bist_ctrl;

    localparam int S = 2;
    localparam int P = S + 1;
`ifdef STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_i, start_i;
    logic       x, y, z, f1, f2;
    logic       busy, done, pass;
    logic [3:0] fc;
    logic [7:0] fv;

    int fault = 0;
    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    logic_eqn_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .x_o        (x),
        .y_o        (y),
        .z_o        (z),
        .f1_i       (f1),
        .f2_i       (f2),
        .busy_o     (busy),
        .done_o     (done),
        .pass_o     (pass),
        .fail_cnt_o (fc),
        .fail_vec_o (fv)
    );

    // Equations evaluated directly from the boolean form, not from tables.
    function automatic bit gold1(input int v);
        bit xx = v[2];
        bit yy = v[1];
        bit zz = v[0];
        return (xx & zz) | (yy & ~zz);
    endfunction

    function automatic bit gold2(input int v);
        bit xx = v[2];
        bit yy = v[1];
        bit zz = v[0];
        return (xx & ~yy) | (yy & ~zz);
    endfunction

    // Fault modes: 0 good, 1 f1 stuck-at-0, 2 f2 inverted, 3 f1 stuck-at-1.
    function automatic bit unit1(input int v, input int m);
        if (m == 1) return 1'b0;
        if (m == 3) return 1'b1;
        return gold1(v);
    endfunction

    function automatic bit unit2(input int v, input int m);
        return (m == 2) ? ~gold2(v) : gold2(v);
    endfunction

    function automatic bit fails(input int v, input int m);
        return (unit1(v, m) != gold1(v)) || (unit2(v, m) != gold2(v));
    endfunction

    function automatic int first_fail(input int m);
        for (int v = 0; v < 8; v++) if (fails(v, m)) return v;
        return 8;
    endfunction

    function automatic int sweep_len(input int m);
        if (STOP && first_fail(m) < 8) return P * (first_fail(m) + 1);
        return P * 8;
    endfunction

    always_comb begin
        f1 = unit1(int'({x, y, z}), fault);
        f2 = unit2(int'({x, y, z}), fault);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: t = cycles since the accepted start edge (-1 = idle after reset).
    int t  = -1;
    int mm = 0;
    initial forever begin
        @(posedge clk);
        if (rst_i) t = -1;
        else if (start_i && !(t >= 0 && t < sweep_len(mm))) begin
            t  = 0;
            mm = fault;
        end else if (t >= 0 && t < sweep_len(mm)) t = t + 1;
    end

    initial forever begin
        int len, tt, e_xyz, e_cnt;
        bit e_busy, e_done, e_pass;
        logic [7:0] e_map;
        @(negedge clk);
        if (cmp_en) begin
            len = sweep_len(mm);
            e_busy = 0; e_done = 0; e_xyz = 0; e_cnt = 0; e_map = 8'h00;
            if (t >= 0) begin
                tt     = (t < len) ? t : len;
                e_busy = (t < len);
                e_done = !e_busy;
                e_xyz  = e_busy ? t / P : len / P - 1;
                for (int v = 0; v < 8; v++) begin
                    if (P * (v + 1) <= tt && fails(v, mm)) begin
                        e_cnt++;
                        e_map[v] = 1'b1;
                    end
                end
            end
            e_pass = e_done && (e_cnt == 0);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("pass", pass, e_pass);
            chk("xyz", {x, y, z}, e_xyz);
            chk("fail_cnt", fc, e_cnt);
            chk("fail_vec", fv, e_map);
        end
    end

    // Pulses start, returns the edge count (start edge = 1) at which done rose,
    // the number of busy cycles and the results seen in the first cycle after start.
    task automatic run_sweep(input int glitch_at, output int edges, output int nbusy,
                             output logic [3:0] fc1, output logic [7:0] fv1);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        edges = 1; nbusy = 0; fc1 = 4'h0; fv1 = 8'h00;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) begin
                fc1 = fc;
                fv1 = fv;
            end
            if (done) break;
            if (busy) nbusy++;
            @(posedge clk); #1;
            edges++;
            start_i = (edges == glitch_at);
        end
        start_i = 1'b0;
        chk("done_reached", done, 1'b1);
    endtask

    initial begin
        int edges, nbusy;
        logic [3:0] fc1;
        logic [7:0] fv1;
        rst_i = 1'b1; start_i = 1'b0; fault = 0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0; cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cnt", fc, 4'd0);
        chk("rst_vec", fv, 8'h00);

        // 1: good unit
        fault = 0;
        run_sweep(0, edges, nbusy, fc1, fv1);
        chk("t1_edges", edges, 25);
        chk("t1_busy_cycles", nbusy, 24);
        chk("t1_pass", pass, 1'b1);
        chk("t1_cnt", fc, 4'd0);
        chk("t1_vec", fv, 8'h00);

        // 2: f1 stuck-at-0
        fault = 1;
        run_sweep(0, edges, nbusy, fc1, fv1);
        chk("t2_pass", pass, 1'b0);
`ifndef STOP_ON_FAIL_EN
        chk("t2_cnt", fc, 4'd4);
        chk("t2_vec", fv, 8'b1110_0100);
`else
        chk("t2_cnt", fc, 4'd1);
        chk("t2_vec", fv, 8'h04);
`endif

        // 3: f2 inverted, then restart from DONE
        fault = 2;
        run_sweep(0, edges, nbusy, fc1, fv1);
`ifndef STOP_ON_FAIL_EN
        chk("t3_cnt", fc, 4'd8);
        chk("t3_vec", fv, 8'hFF);
`endif
        fault = 0;
        run_sweep(0, edges, nbusy, fc1, fv1);
        chk("t3_restart_cnt", fc1, 4'd0);
        chk("t3_restart_vec", fv1, 8'h00);
        chk("t3_restart_pass", pass, 1'b1);

        // 4: start pulsed while busy at vec 4
        run_sweep(13, edges, nbusy, fc1, fv1);
        chk("t4_edges", edges, 25);
        chk("t4_pass", pass, 1'b1);

        // 5: reset at vec 3
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_i = 1'b1;
        @(negedge clk);
        chk("t5_pre_xyz", {x, y, z}, 3'd3);
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_xyz", {x, y, z}, 3'd0);
        chk("t5_cnt", fc, 4'd0);
        run_sweep(0, edges, nbusy, fc1, fv1);
        chk("t5_edges", edges, 25);
        chk("t5_pass", pass, 1'b1);

`ifdef STOP_ON_FAIL_EN
        // 6: stop on first fail, f1 stuck-at-1 fails at vector 0
        fault = 3;
        run_sweep(0, edges, nbusy, fc1, fv1);
        chk("t6_edges", edges, 4);
        chk("t6_cnt", fc, 4'd1);
        chk("t6_vec", fv, 8'h01);
        chk("t6_xyz", {x, y, z}, 3'd0);
`endif

        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
